// File: rtl/ddr_rx_pkg.sv
// ddr_rx_pkg: shared constants, FSM state type and the single-bit CRC5 step
// for the HDR-DDR receive path.
//   CRC5_SEED / CRC5_POLY : CRC register reset value and feedback taps
//                           (G(x) = x^5 + x^2 + 1, x^5 implicit)
//   crc_state_t           : IDLE / SHIFT / DONE
//   crc5_bit_step()       : advance the CRC register by one data bit
package ddr_rx_pkg;

    localparam int unsigned CRC_W    = 5;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned BITCNT_W = 3;

    localparam logic [CRC_W-1:0] CRC5_SEED = 5'h1F;
    localparam logic [CRC_W-1:0] CRC5_POLY = 5'h05;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } crc_state_t;

    // One serial CRC step, data bit presented MSB first.
    function automatic logic [CRC_W-1:0] crc5_bit_step(
        input logic [CRC_W-1:0] crc,
        input logic             data_bit,
        input logic [CRC_W-1:0] poly = CRC5_POLY
    );
        logic fb;
        fb = crc[CRC_W-1] ^ data_bit;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/ddr_rx_byte_fifo.sv
// ddr_rx_byte_fifo: small synchronous byte FIFO with flush.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : empties the FIFO; a same-cycle push lands as entry 0
//   push, din     : write request and data (ignored when full unless popping)
//   pop           : read request, advances the read pointer
//   dout_c        : head-of-queue data (combinational)
//   full_c/empty_c: occupancy flags (combinational from registers)
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module ddr_rx_byte_fifo #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout_c,
    output logic              full_c,
    output logic              empty_c
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_idx;
    logic [CW-1:0]     count;
    logic              wr_en;
    logic              rd_en;

    assign full_c  = (count == CW'(FIFO_DEPTH));
    assign empty_c = (count == '0);
    assign rd_en   = pop & ~empty_c & ~flush & ~rst;
    // A full FIFO still accepts a byte when the same cycle pops or flushes.
    assign wr_en   = push & ~rst & (flush | ~full_c | rd_en);
    assign wr_idx  = flush ? AW'(0) : wr_ptr;
    assign dout_c  = mem[rd_ptr];

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= wr_en ? AW'(1) : AW'(0);
            count  <= wr_en ? CW'(1) : CW'(0);
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= din;
    end

endmodule

// File: rtl/ddr_rx_crc5_engine.sv
// ddr_rx_crc5_engine: serial HDR-DDR CRC5 over the RX data bytes.
// Bytes are queued in a small FIFO and shifted one bit per clock, MSB first.
//   i_sys_clk, i_sys_rst : clock, synchronous active-high reset
//   i_crc_init           : frame start; reloads seed, flushes, clears flags
//   i_rx_byte_valid/byte : deserialized byte strobe and data
//   i_crc_en             : RX result request (level)
//   o_crc_value          : current CRC register
//   o_crc_valid          : CRC final for all accepted bytes (DONE state)
//   o_crc_busy           : FIFO not empty or shift in progress
//   o_crc_overflow       : sticky; a byte was dropped on a full FIFO
// Optional (macro DDR_RX_CRC5_COMPARE_EN):
//   i_rx_crc_rcvd        : CRC word received on the bus
//   o_crc_error          : sticky; received CRC differed when valid rose
module ddr_rx_crc5_engine
    import ddr_rx_pkg::*;
#(
    parameter logic [CRC_W-1:0] CRC_SEED   = CRC5_SEED,
    parameter logic [CRC_W-1:0] CRC_POLY   = CRC5_POLY,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_crc_init,
    input  logic              i_rx_byte_valid,
    input  logic [BYTE_W-1:0] i_rx_byte,
    input  logic              i_crc_en,
`ifdef DDR_RX_CRC5_COMPARE_EN
    input  logic [CRC_W-1:0]  i_rx_crc_rcvd,
    output logic              o_crc_error,
`endif
    output logic [CRC_W-1:0]  o_crc_value,
    output logic              o_crc_valid,
    output logic              o_crc_busy,
    output logic              o_crc_overflow
);

    crc_state_t           state_q, state_d;
    logic [CRC_W-1:0]     crc_q, crc_d;
    logic [BYTE_W-1:0]    sr_q, sr_d;
    logic [BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic                 pop;
    logic                 drop;
    logic [BYTE_W-1:0]    fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;

    ddr_rx_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (BYTE_W)
    ) u_fifo (
        .clk     (i_sys_clk),
        .rst     (i_sys_rst),
        .flush   (i_crc_init),
        .push    (i_rx_byte_valid),
        .din     (i_rx_byte),
        .pop     (pop),
        .dout_c  (fifo_dout),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    // Next-state and datapath logic.
    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    sr_d     = fifo_dout;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end else if (i_crc_en) begin
                    state_d = DONE;
                end
            end
            SHIFT: begin
                crc_d    = crc5_bit_step(crc_q, sr_q[BYTE_W-1], CRC_POLY);
                sr_d     = {sr_q[BYTE_W-2:0], 1'b0};
                bitcnt_d = bitcnt_q + BITCNT_W'(1);
                // Last bit of the byte: chain straight into the next one.
                if (bitcnt_q == BITCNT_W'(BYTE_W - 1)) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        sr_d     = fifo_dout;
                        bitcnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                if (!i_crc_en) begin
                    state_d = IDLE;
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    sr_d     = fifo_dout;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_crc_init) begin
            state_d = IDLE;
            crc_d   = CRC_SEED;
            pop     = 1'b0;
        end

        drop    = i_rx_byte_valid & fifo_full & ~pop & ~i_crc_init;
        ovf_d   = i_crc_init ? 1'b0 : (ovf_q | drop);
        valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q  <= IDLE;
            crc_q    <= CRC_SEED;
            sr_q     <= '0;
            bitcnt_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_crc_value    = crc_q;
    assign o_crc_valid    = valid_q;
    assign o_crc_overflow = ovf_q;
    assign o_crc_busy     = (state_q == SHIFT) | ~fifo_empty;

`ifdef DDR_RX_CRC5_COMPARE_EN
    logic err_q, err_d;

    // Compare only on the rising edge of valid, when the CRC is final.
    always_comb begin
        err_d = err_q;
        if (i_crc_init) begin
            err_d = 1'b0;
        end else if (valid_d && !valid_q && (i_rx_crc_rcvd != crc_d)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) err_q <= 1'b0;
        else           err_q <= err_d;
    end

    assign o_crc_error = err_q;
`endif

endmodule

// File: tb/tb_ddr_rx_crc5_engine.sv
// tb_ddr_rx_crc5_engine: directed plus randomized checks of the CRC5 engine
// against a queue-based reference CRC computed with plain integer arithmetic.
module tb_ddr_rx_crc5_engine;

    typedef logic [7:0] byte_q_t[$];

    logic       i_sys_clk = 1'b0;
    logic       i_sys_rst;
    logic       i_crc_init;
    logic       i_rx_byte_valid;
    logic [7:0] i_rx_byte;
    logic       i_crc_en;
    logic [4:0] o_crc_value;
    logic       o_crc_valid;
    logic       o_crc_busy;
    logic       o_crc_overflow;
`ifdef DDR_RX_CRC5_COMPARE_EN
    logic [4:0] i_rx_crc_rcvd;
    logic       o_crc_error;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_sys_clk = ~i_sys_clk;

    ddr_rx_crc5_engine dut (
        .i_sys_clk       (i_sys_clk),
        .i_sys_rst       (i_sys_rst),
        .i_crc_init      (i_crc_init),
        .i_rx_byte_valid (i_rx_byte_valid),
        .i_rx_byte       (i_rx_byte),
        .i_crc_en        (i_crc_en),
`ifdef DDR_RX_CRC5_COMPARE_EN
        .i_rx_crc_rcvd   (i_rx_crc_rcvd),
        .o_crc_error     (o_crc_error),
`endif
        .o_crc_value     (o_crc_value),
        .o_crc_valid     (o_crc_valid),
        .o_crc_busy      (o_crc_busy),
        .o_crc_overflow  (o_crc_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Polynomial division remainder, bytes MSB first, G = 100101b.
    function automatic logic [4:0] ref_crc(input byte_q_t q);
        int r;
        r = 'h1F;
        foreach (q[i]) begin
            int v;
            v = int'(q[i]);
            for (int b = 7; b >= 0; b--) begin
                int in_bit;
                int msb;
                in_bit = (v >> b) & 1;
                msb    = (r >> 4) & 1;
                r      = r << 1;
                if (msb != in_bit) r = r ^ 'h25;
                r = r & 'h1F;
            end
        end
        return 5'(r);
    endfunction

    task automatic step();
        @(posedge i_sys_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        i_rx_byte_valid = 1'b1;
        i_rx_byte       = b;
        step();
        i_rx_byte_valid = 1'b0;
    endtask

    task automatic init_pulse();
        i_crc_init = 1'b1;
        step();
        i_crc_init = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k;
        k = 0;
        while (o_crc_busy && k < bound) begin
            step();
            k++;
        end
        if (o_crc_busy) check(tag, 32'(o_crc_busy), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int k;
        k = 0;
        while (!o_crc_valid && k < bound) begin
            step();
            k++;
        end
        if (!o_crc_valid) check(tag, 32'(o_crc_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t q;
        int      rise;
        int      cnt;
        logic [7:0] b;
        logic [4:0] exp;

        i_sys_rst       = 1'b1;
        i_crc_init      = 1'b0;
        i_rx_byte_valid = 1'b0;
        i_rx_byte       = 8'h00;
        i_crc_en        = 1'b0;
`ifdef DDR_RX_CRC5_COMPARE_EN
        i_rx_crc_rcvd   = 5'h00;
`endif
        repeat (3) step();
        check("rst_value", 32'(o_crc_value), 32'h1F);
        check("rst_valid", 32'(o_crc_valid), 32'd0);
        check("rst_busy",  32'(o_crc_busy),  32'd0);
        check("rst_ovf",   32'(o_crc_overflow), 32'd0);
        i_sys_rst = 1'b0;
        step();

        // Seed, one byte: valid rises exactly 10 cycles after the push.
        init_pulse();
        push_byte(8'h00);
        i_crc_en = 1'b1;
        rise = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (o_crc_valid) begin
                rise = k;
                break;
            end
        end
        check("one_byte_latency", 32'(rise), 32'd10);
        check("one_byte_value", 32'(o_crc_value), 32'h0F);
        i_crc_en = 1'b0;
        step();
        check("valid_fall", 32'(o_crc_valid), 32'd0);

        // Two bytes back-to-back: 17 busy cycles, no bubble.
        init_pulse();
        i_rx_byte_valid = 1'b1;
        i_rx_byte       = 8'h00;
        step();
        cnt = o_crc_busy ? 1 : 0;
        step();
        i_rx_byte_valid = 1'b0;
        if (o_crc_busy) cnt++;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_crc_busy) cnt++;
            else break;
        end
        check("two_byte_busy", 32'(cnt), 32'd17);
        check("two_byte_value", 32'(o_crc_value), 32'h01);

        // Overflow: three pushes fit, further pushes while shifting drop.
        init_pulse();
        q = {};
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            push_byte(b);
        end
        check("ovf_three_ok", 32'(o_crc_overflow), 32'd0);
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        check("ovf_set", 32'(o_crc_overflow), 32'd1);
        wait_idle("ovf_idle_timeout", 100);
        check("ovf_value", 32'(o_crc_value), 32'(ref_crc(q)));
        check("ovf_sticky", 32'(o_crc_overflow), 32'd1);
        init_pulse();
        check("ovf_cleared", 32'(o_crc_overflow), 32'd0);
        check("init_seed", 32'(o_crc_value), 32'h1F);

        // Init in the middle of a shift.
        push_byte(8'hA5);
        repeat (4) step();
        check("mid_busy_pre", 32'(o_crc_busy), 32'd1);
        init_pulse();
        check("mid_init_value", 32'(o_crc_value), 32'h1F);
        check("mid_init_busy", 32'(o_crc_busy), 32'd0);
        check("mid_init_valid", 32'(o_crc_valid), 32'd0);
        repeat (10) step();
        check("mid_init_hold", 32'(o_crc_value), 32'h1F);

        // Reset mid-operation, with a byte presented during reset.
        init_pulse();
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        check("rst_pre_ovf", 32'(o_crc_overflow), 32'd1);
        i_sys_rst       = 1'b1;
        i_rx_byte_valid = 1'b1;
        i_rx_byte       = 8'($urandom);
        i_crc_en        = 1'b1;
        step();
        i_sys_rst       = 1'b0;
        i_rx_byte_valid = 1'b0;
        i_crc_en        = 1'b0;
        check("mrst_value", 32'(o_crc_value), 32'h1F);
        check("mrst_valid", 32'(o_crc_valid), 32'd0);
        check("mrst_busy",  32'(o_crc_busy),  32'd0);
        check("mrst_ovf",   32'(o_crc_overflow), 32'd0);
        repeat (12) step();
        check("mrst_ignored_busy", 32'(o_crc_busy), 32'd0);
        check("mrst_ignored_value", 32'(o_crc_value), 32'h1F);

`ifdef DDR_RX_CRC5_COMPARE_EN
        // Received CRC comparison, match then mismatch.
        init_pulse();
        i_rx_crc_rcvd = 5'h0F;
        push_byte(8'h00);
        i_crc_en = 1'b1;
        wait_valid("cmp_ok_timeout", 40);
        check("cmp_ok_error", 32'(o_crc_error), 32'd0);
        i_crc_en = 1'b0;
        step();
        init_pulse();
        i_rx_crc_rcvd = 5'h0E;
        push_byte(8'h00);
        i_crc_en = 1'b1;
        wait_valid("cmp_bad_timeout", 40);
        check("cmp_bad_error", 32'(o_crc_error), 32'd1);
        i_crc_en = 1'b0;
        step();
        init_pulse();
        check("cmp_init_clear", 32'(o_crc_error), 32'd0);
`endif

        // Randomized frames checked against the reference CRC.
        for (int f = 0; f < 30; f++) begin
            q = {};
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom);
                i_crc_init      = 1'b1;
                i_rx_byte_valid = 1'b1;
                i_rx_byte       = b;
                step();
                i_crc_init      = 1'b0;
                i_rx_byte_valid = 1'b0;
                q.push_back(b);
            end else begin
                init_pulse();
            end
            cnt = int'($urandom_range(1, 5));
            for (int i = 0; i < cnt; i++) begin
                if (q.size() != 0) repeat ($urandom_range(7, 11)) step();
                b = 8'($urandom);
                q.push_back(b);
                push_byte(b);
            end
            exp = ref_crc(q);
`ifdef DDR_RX_CRC5_COMPARE_EN
            i_rx_crc_rcvd = ($urandom_range(0, 1) == 0) ? exp : 5'($urandom);
`endif
            repeat ($urandom_range(0, 12)) step();
            i_crc_en = 1'b1;
            wait_valid("rand_valid_timeout", 200);
            check("rand_value", 32'(o_crc_value), 32'(exp));
            check("rand_busy", 32'(o_crc_busy), 32'd0);
            check("rand_ovf", 32'(o_crc_overflow), 32'd0);
`ifdef DDR_RX_CRC5_COMPARE_EN
            check("rand_error", 32'(o_crc_error), 32'(i_rx_crc_rcvd != exp));
`endif
            i_crc_en = 1'b0;
            step();
            check("rand_valid_fall", 32'(o_crc_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_rx_crc5_engine.md
Name: ddr_rx_crc5_engine

Overview:
- Computes the HDR-DDR CRC5 over the data bytes delivered by the RX deserializer, and returns the 5-bit CRC value and a valid flag back to RX for its CHECK_CRC_VALUE mode.
- Sits directly downstream of RX: it consumes each deserialized byte and answers RX's CRC enable request.
- Buffers bytes in a small FIFO and processes them serially, one bit per i_sys_clk, MSB first.

Parameters:
- CRC_SEED, 5'h1F, CRC register value after reset and after i_crc_init.
- CRC_POLY, 5'h05, feedback taps for G(x)=x^5+x^2+1 (the x^5 term is implicit).
- FIFO_DEPTH, 2, byte buffer entries; must be a power of 2, minimum 2.

Ports:
- i_sys_clk  in  1  system clock; the block's only clock.
- i_sys_rst  in  1  synchronous, active-high reset.
- i_crc_init  in  1  one-cycle pulse at the start of a data frame; reloads the seed and flushes the block.
- i_rx_byte_valid  in  1  one-cycle strobe; i_rx_byte holds a completed byte.
- i_rx_byte  in  8  deserialized data byte.
- i_crc_en  in  1  level; RX requests the result (held high during CHECK_CRC_VALUE).
- o_crc_value  out  5  current CRC register.
- o_crc_valid  out  1  o_crc_value is final for all accepted bytes.
- o_crc_busy  out  1  FIFO not empty or shift in progress.
- o_crc_overflow  out  1  sticky flag; a byte was dropped because the FIFO was full.

Behaviour:
- Reset: synchronous, checked at i_sys_clk posedge and overrides all other inputs. Clears the FIFO, clears the bit counter and goes to IDLE.
- Output reset values: o_crc_value=CRC_SEED, o_crc_valid=0, o_crc_busy=0, o_crc_overflow=0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if the FIFO is not empty, pop into the shift register, set bitcnt=0 and go to SHIFT.
  - IDLE: else if i_crc_en=1, go to DONE.
  - SHIFT: each cycle, fb = crc[4] ^ sr[7]; crc <= {crc[3:0],1'b0} ^ (fb ? CRC_POLY : 0); sr <= sr<<1; bitcnt++.
  - SHIFT, at bitcnt=7: if the FIFO is not empty, pop the next byte and stay in SHIFT (no bubble); else go to IDLE.
  - DONE: o_crc_valid=1 while i_crc_en=1. A byte arriving in DONE is still accepted; the FSM drops valid and goes to SHIFT. When i_crc_en falls, go to IDLE.
- Latency: a byte accepted into an empty FIFO in IDLE at cycle T shifts during T+1..T+8, and the CRC is final at the end of T+8.
  - If i_crc_en is already high, o_crc_valid asserts at T+10 (IDLE at T+9, DONE at T+10).
  - If i_crc_en rises while busy, valid waits until the block drains.
- o_crc_valid is registered, asserts only in DONE, and deasserts the cycle after i_crc_en falls.
- FIFO push and pop:
  - Push on i_rx_byte_valid.
  - Push to a full FIFO without a same-cycle pop: byte dropped, o_crc_overflow set. The flag stays set until i_crc_init or reset.
  - Push and pop in the same cycle with the FIFO full: legal, no drop.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- i_crc_init:
  - Aborts any shift, flushes the FIFO, loads CRC_SEED, clears o_crc_overflow and o_crc_valid, and goes to IDLE.
  - If i_rx_byte_valid is high in the same cycle, that byte is pushed into the freshly flushed FIFO as the first byte of the new frame.
- i_crc_init together with i_crc_en: init takes effect; valid is re-evaluated from IDLE.
- o_crc_busy = (state==SHIFT) | FIFO not empty, combinational from registers.

Optional Feature:
- Macro: DDR_RX_CRC5_COMPARE_EN.
- With the macro defined, the block adds:
  - input i_rx_crc_rcvd[4:0]: the CRC word received on the bus.
  - output o_crc_error, registered: set on the cycle o_crc_valid rises if i_rx_crc_rcvd != o_crc_value; cleared by i_crc_init or reset.
- Without the macro, both ports are absent and the CRC comparison remains in RX.

Decomposition:
- Shared package ddr_rx_pkg holds:
  - CRC5_SEED and CRC5_POLY constants.
  - crc_state_t enum (IDLE, SHIFT, DONE).
  - function crc5_bit_step(crc, bit).
- One sub-module, ddr_rx_byte_fifo: synchronous FIFO, parameter FIFO_DEPTH, with push/pop/full/empty/flush.

Test Plan:
- Seed, one byte: i_crc_init, push 8'h00, then hold i_crc_en=1 -> o_crc_value=5'h0F; o_crc_valid rises exactly 10 cycles after the push.
- Two bytes back-to-back: push 8'h00 on 2 consecutive cycles -> no bubble between bytes, o_crc_value=5'h01, o_crc_busy high for 17 cycles.
- Overflow: push 3 bytes on consecutive cycles with FIFO_DEPTH=2 while idle -> first pop frees a slot, so all 3 are accepted. Then push 4 bytes while the first is still shifting -> o_crc_overflow=1, which stays set until i_crc_init.
- i_crc_init mid-shift: push 8'hA5, assert i_crc_init on cycle 4 of its shift -> o_crc_value=5'h1F next cycle, FSM in IDLE, o_crc_busy=0.
- Reset mid-operation: assert i_sys_rst while in SHIFT with 1 byte queued -> all outputs return to their reset values next cycle; a byte presented during reset is ignored.
- With DDR_RX_CRC5_COMPARE_EN: push 8'h00, i_rx_crc_rcvd=5'h0F -> o_crc_error=0; repeat with 5'h0E -> o_crc_error=1 on the cycle o_crc_valid rises.
